// File: rtl/multi_div_freq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multi_div_freq                                               |
// | Description : N-channel programmable 50%-duty clock divider with per-      |
// |               channel rise ticks, runtime half-period writes applied at    |
// |               full-period boundaries, and a power-up start delay.          |
// |               Optional macro DIV_ALIGN_EN adds an align input that         |
// |               restarts every running channel phase-aligned.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multi_div_freq #(
  parameter int N_CH      = 2,
  parameter int CNT_W     = 8,
  parameter int DEF_HALF0 = 22,
  parameter int DEF_HALF1 = 21,
  parameter int DELAY     = 1000,
  parameter int SEL_W     = 3
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             div_wr,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [CNT_W-1:0] div_data,
`ifdef DIV_ALIGN_EN
  input  logic             align,
`endif
  output logic             wr_err,
  output logic             start,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  localparam int               c_dly_w    = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [c_dly_w-1:0] c_dly_last = c_dly_w'(DELAY - 1);
  localparam logic [SEL_W:0]   c_nch      = (SEL_W + 1)'(N_CH);

  logic [c_dly_w-1:0] r_dly_cnt;
  logic               w_wr_bad;
  logic               w_wr_ok;
  logic               w_align;

`ifdef DIV_ALIGN_EN
  assign w_align = align;
`else
  assign w_align = 1'b0;
`endif

  // A write is rejected when it addresses a missing channel or asks for a zero half-period.
  assign w_wr_bad = div_wr && (({1'b0, div_sel} >= c_nch) || (div_data == '0));
  assign w_wr_ok  = div_wr && !w_wr_bad;

  // Power-up delay: count cycles after reset release, then latch start and freeze.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_dly_cnt <= '0;
      start     <= 1'b0;
    end else if (!start) begin
      if (r_dly_cnt == c_dly_last) begin
        start <= 1'b1;
      end else begin
        r_dly_cnt <= r_dly_cnt + 1'b1;
      end
    end
  end

  // Rejected writes flag a single-cycle error pulse.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= w_wr_bad;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [CNT_W-1:0] c_def = (i == 0) ? CNT_W'(DEF_HALF0) : CNT_W'(DEF_HALF1);
    localparam logic [SEL_W-1:0] c_idx = SEL_W'(i);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_pend;
    logic             r_pflag;
    logic             r_clk;
    logic             r_tick;
    logic             w_run;
    logic             w_wrap;
    logic             w_sel;

    // A channel that is high keeps running after ch_en drops so the high phase is never cut short.
    assign w_run  = start && (ch_en[i] || r_clk);
    assign w_wrap = (r_cnt == (r_half - 1'b1));
    assign w_sel  = w_wr_ok && (div_sel == c_idx);

    // Half-period counter, output toggle, tick and pending-ratio hand-over.
    always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
        r_cnt   <= '0;
        r_half  <= c_def;
        r_pend  <= c_def;
        r_pflag <= 1'b0;
        r_clk   <= 1'b0;
        r_tick  <= 1'b0;
      end else begin
        r_tick <= 1'b0;
        if (!w_run) begin
          // Idle channel: no period in flight, so a pending ratio can land at once.
          r_cnt <= '0;
          if (r_pflag) begin
            r_half  <= r_pend;
            r_pflag <= 1'b0;
          end
        end else if (w_align) begin
          r_cnt <= '0;
          r_clk <= 1'b0;
          if (r_pflag) begin
            r_half  <= r_pend;
            r_pflag <= 1'b0;
          end
        end else if (w_wrap) begin
          r_cnt  <= '0;
          r_clk  <= ~r_clk;
          r_tick <= ~r_clk;
          // Falling wrap ends a full period: the only safe point to change ratio.
          if (r_clk && r_pflag) begin
            r_half  <= r_pend;
            r_pflag <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        // A write in the same cycle as an apply becomes the next pending value.
        if (w_sel) begin
          r_pend  <= div_data;
          r_pflag <= 1'b1;
        end
      end
    end

    assign clk_out[i] = r_clk;
    assign tick[i]    = r_tick;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_div_freq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multi_div_freq                                            |
// | Description : Self-checking bench for multi_div_freq against a period-     |
// |               position reference model (DIV_ALIGN_EN optional).            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_multi_div_freq;
  localparam int N_CH  = 2;
  localparam int CNT_W = 8;
  localparam int SEL_W = 3;
  localparam int DELAY = 1000;
`ifdef DIV_ALIGN_EN
  localparam bit HAS_ALIGN = 1'b1;
`else
  localparam bit HAS_ALIGN = 1'b0;
`endif

  logic             clk_in = 1'b0;
  logic             rst;
  logic [N_CH-1:0]  ch_en;
  logic             div_wr;
  logic [SEL_W-1:0] div_sel;
  logic [CNT_W-1:0] div_data;
  logic             align;
  logic             wr_err;
  logic             start;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;

  always #5 clk_in = ~clk_in;

  multi_div_freq dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .ch_en    (ch_en),
    .div_wr   (div_wr),
    .div_sel  (div_sel),
    .div_data (div_data),
`ifdef DIV_ALIGN_EN
    .align    (align),
`endif
    .wr_err   (wr_err),
    .start    (start),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: each channel tracks its position inside a full period of 2*half cycles.
  int m_cyc;
  bit m_start;
  bit m_err;
  int m_p[N_CH];
  int m_h[N_CH];
  int m_pend[N_CH];
  bit m_pf[N_CH];
  bit m_out[N_CH];
  bit m_tick[N_CH];

  typedef struct {
    logic             wr;
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] data;
    logic             exp_err;
  } wvec_t;
  wvec_t tbl[6];

  function automatic void model_reset();
    m_cyc   = 0;
    m_start = 1'b0;
    m_err   = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      m_h[c]    = (c == 0) ? 22 : 21;
      m_pend[c] = m_h[c];
      m_p[c]    = 0;
      m_pf[c]   = 1'b0;
      m_out[c]  = 1'b0;
      m_tick[c] = 1'b0;
    end
  endfunction

  function automatic void model_step(input logic [N_CH-1:0] en, input logic wr,
                                     input logic [SEL_W-1:0] sel, input logic [CNT_W-1:0] data,
                                     input logic al);
    bit ok;
    bit run;
    ok    = wr && (int'(sel) < N_CH) && (data != 0);
    m_err = wr && !ok;
    for (int c = 0; c < N_CH; c++) begin
      run       = m_start && (en[c] || m_out[c]);
      m_tick[c] = 1'b0;
      if (!run) begin
        m_p[c] = 0;
        if (m_pf[c]) begin m_h[c] = m_pend[c]; m_pf[c] = 1'b0; end
      end else if (al && HAS_ALIGN) begin
        m_p[c]   = 0;
        m_out[c] = 1'b0;
        if (m_pf[c]) begin m_h[c] = m_pend[c]; m_pf[c] = 1'b0; end
      end else begin
        m_p[c] = m_p[c] + 1;
        if (m_p[c] == m_h[c]) begin
          m_out[c]  = 1'b1;
          m_tick[c] = 1'b1;
        end else if (m_p[c] == 2 * m_h[c]) begin
          m_p[c]   = 0;
          m_out[c] = 1'b0;
          if (m_pf[c]) begin m_h[c] = m_pend[c]; m_pf[c] = 1'b0; end
        end
      end
      if (ok && int'(sel) == c) begin
        m_pend[c] = data;
        m_pf[c]   = 1'b1;
      end
    end
    if (!m_start) begin
      m_cyc = m_cyc + 1;
      if (m_cyc >= DELAY) m_start = 1'b1;
    end
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the current inputs, then compare every output.
  task automatic cycle();
    if (rst) model_reset();
    else model_step(ch_en, div_wr, div_sel, div_data, align);
    @(posedge clk_in);
    #1;
    check("outputs", {26'd0, wr_err, start, tick, clk_out},
          {26'd0, m_err, m_start, m_tick[1], m_tick[0], m_out[1], m_out[0]});
  endtask

  task automatic wait_tick(input int ch, input int lim, output int n);
    n = 0;
    while (!tick[ch] && n < lim) begin
      cycle();
      n++;
    end
    if (!tick[ch]) begin
      total++;
      bad++;
      $display("FAIL tick_timeout ch=%0d actual=0 required=1", ch);
    end
  endtask

  // Called on a tick sample: rise-to-rise length and high-cycle count.
  task automatic measure(input int ch, output int per, output int hi);
    per = 0;
    hi  = 0;
    do begin
      if (clk_out[ch]) hi++;
      cycle();
      per++;
    end while (!tick[ch] && per < 600);
  endtask

  initial begin
    int n, per, hi;
    tbl[0] = '{1'b1, 3'd0, 8'd5,  1'b0};
    tbl[1] = '{1'b1, 3'd3, 8'd5,  1'b1};
    tbl[2] = '{1'b1, 3'd0, 8'd0,  1'b1};
    tbl[3] = '{1'b1, 3'd7, 8'd9,  1'b1};
    tbl[4] = '{1'b1, 3'd1, 8'd21, 1'b0};
    tbl[5] = '{1'b0, 3'd3, 8'd0,  1'b0};

    rst = 1'b1; ch_en = 2'b11; div_wr = 1'b0; div_sel = '0; div_data = '0; align = 1'b0;
    model_reset();
    repeat (3) cycle();
    check("reset_state", {26'd0, wr_err, start, tick, clk_out}, 32'd0);

    // Start delay
    rst = 1'b0;
    repeat (DELAY - 1) cycle();
    check("start_early", start, 1'b0);
    check("clk_before_start", clk_out, 2'b00);
    cycle();
    check("start_on", start, 1'b1);

    // Default ratios
    wait_tick(0, 100, n);
    measure(0, per, hi);
    check("ch0_period", per, 44);
    check("ch0_high", hi, 22);
    wait_tick(1, 100, n);
    measure(1, per, hi);
    check("ch1_period", per, 42);
    check("ch1_high", hi, 21);

    // Ratio write during high phase of ch0
    wait_tick(0, 100, n);
    n = 0;
    while (clk_out[0] && n < 100) begin
      if (n == 3) begin div_wr = 1'b1; div_sel = 3'd0; div_data = 8'd5; end
      else div_wr = 1'b0;
      n++;
      cycle();
    end
    div_wr = 1'b0;
    check("hi_phase_kept", n, 22);
    wait_tick(0, 100, n);
    check("new_low_phase", n, 5);
    measure(0, per, hi);
    check("new_period", per, 10);
    check("new_high", hi, 5);

    // Write vector table
    for (int i = 0; i < 6; i++) begin
      div_wr = tbl[i].wr; div_sel = tbl[i].sel; div_data = tbl[i].data;
      cycle();
      check("wr_err_vec", wr_err, tbl[i].exp_err);
      div_wr = 1'b0;
      cycle();
      check("wr_err_single", wr_err, 1'b0);
    end
    wait_tick(1, 100, n);
    measure(1, per, hi);
    check("ch1_unchanged", per, 42);
    wait_tick(0, 100, n);
    measure(0, per, hi);
    check("ch0_unchanged", per, 10);

    // Disable ch1 during its high phase, then re-enable
    wait_tick(1, 100, n);
    ch_en = 2'b01;
    n = 0;
    while (clk_out[1] && n < 100) begin n++; cycle(); end
    check("dis_high_len", n, 21);
    repeat (30) cycle();
    check("dis_hold", clk_out[1], 1'b0);
    ch_en = 2'b11;
    wait_tick(1, 100, n);
    check("reen_first_rise", n, 21);

    // Randomized traffic against the model
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 15) == 0) ch_en = 2'($urandom);
      div_wr   = ($urandom_range(0, 5) == 0);
      div_sel  = 3'($urandom_range(0, 3));
      div_data = 8'($urandom_range(0, 8));
      cycle();
    end
    div_wr = 1'b0; ch_en = 2'b11;

    // Asynchronous reset mid-operation restores defaults
    #3 rst = 1'b1;
    #1 check("async_rst", {26'd0, wr_err, start, tick, clk_out}, 32'd0);
    model_reset();
    @(posedge clk_in);
    #1;
    cycle();
    rst = 1'b0;
    repeat (DELAY) cycle();
    check("restart", start, 1'b1);
    wait_tick(0, 100, n);
    measure(0, per, hi);
    check("ch0_default_again", per, 44);

`ifdef DIV_ALIGN_EN
    wait_tick(1, 100, n);
    repeat (3) cycle();
    align = 1'b1;
    cycle();
    align = 1'b0;
    check("align_low", {tick, clk_out}, 4'b0000);
    wait_tick(1, 100, n);
    check("align_ch1_rise", n, 21);
    wait_tick(0, 100, n);
    check("align_ch0_rise", n, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
